// File: rtl/lagartoII_const.sv
// Shared LagartoII constants and the fetch-stage state encoding.
package lagartoII_const;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [WORD_WIDTH-1:0] PC_STEP  = 32'd4;
    localparam logic [WORD_WIDTH-1:0] NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_RESET = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; the head output holds its last shown value while empty.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    // Pointer and occupancy update; flush empties the queue and drops a same-cycle push.
    always_comb begin
        do_pop   = 1'b0;
        do_push  = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed while occupied, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Remember the most recently presented head so the output holds once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (count_q != '0) begin
            last_q <= mem_q[rd_ptr_q];
        end
    end

    assign head_c = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign count  = count_q;

endmodule

// File: rtl/fetch_unit.sv
// LagartoII instruction fetch: PC, credit-limited imem requests, instruction buffer, redirect flush.
module fetch_unit #(
    parameter int unsigned WORD_WIDTH = lagartoII_const::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0] RESET_PC = WORD_WIDTH'(lagartoII_const::RESET_PC),
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  imem_req_o,
    output logic [WORD_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [WORD_WIDTH-1:0] redirect_pc_i,
    output logic                  id_valid_o,
    output logic [WORD_WIDTH-1:0] id_instr_o,
    output logic [WORD_WIDTH-1:0] id_pc_o,
    input  logic                  id_ready_i
);

    import lagartoII_const::fetch_state_e;
    import lagartoII_const::FETCH_RESET;
    import lagartoII_const::FETCH_RUN;
    import lagartoII_const::FETCH_FLUSH;

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = 2 * WORD_WIDTH;
    localparam logic [WORD_WIDTH-1:0] STEP       = WORD_WIDTH'(lagartoII_const::PC_STEP);
    localparam logic [WORD_WIDTH-1:0] ALIGN_MASK = ~WORD_WIDTH'(3);
    localparam logic [CNT_W:0]        CREDITS    = (CNT_W + 1)'(DEPTH);

    fetch_state_e          state_q, state_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]      discard_q, discard_d;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      buf_count;
    logic [CNT_W:0]        in_use;
    logic [ENTRY_W-1:0]    buf_head;
    logic [WORD_WIDTH-1:0] pend_pc;
    logic                  grant;
    logic                  buf_push;
    logic                  buf_pop;

    // Request credits, PC/discard next values and the fetch state machine.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        in_use     = '0;
        imem_req_o = 1'b0;
        grant      = 1'b0;
        buf_push   = 1'b0;
        buf_pop    = 1'b0;

        in_use     = (CNT_W + 1)'(outstanding) + (CNT_W + 1)'(buf_count);
        imem_req_o = (state_q != FETCH_RESET) && !redirect_i && (in_use < CREDITS);
        grant      = imem_req_o && imem_gnt_i;
        buf_push   = imem_rvalid_i && !redirect_i && (discard_q == '0);
        buf_pop    = (buf_count != '0) && id_ready_i && !redirect_i;

        if (redirect_i) begin
            // Every request in flight is wrong-path, including one answering this cycle.
            pc_d      = redirect_pc_i & ALIGN_MASK;
            discard_d = (imem_rvalid_i && (outstanding != '0)) ? outstanding - CNT_W'(1)
                                                               : outstanding;
        end else begin
            if (grant) begin
                pc_d = pc_q + STEP;
            end
            if (imem_rvalid_i && (discard_q != '0)) begin
                discard_d = discard_q - CNT_W'(1);
            end
        end

        case (state_q)
            FETCH_RESET: state_d = FETCH_RUN;
            FETCH_RUN:   if (discard_d != '0) state_d = FETCH_FLUSH;
            FETCH_FLUSH: if (discard_d == '0) state_d = FETCH_RUN;
            default:     state_d = FETCH_RUN;
        endcase
    end

    // State, PC and discard counter registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= FETCH_RESET;
            pc_q      <= RESET_PC;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    // Issued PCs awaiting their response; its occupancy is the outstanding count.
    fetch_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH)
    ) u_pend_q (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .flush     (1'b0),
        .push      (grant),
        .push_data (pc_q),
        .pop       (imem_rvalid_i),
        .head_c    (pend_pc),
        .count     (outstanding)
    );

    // {pc, instr} buffer feeding decode.
    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk       (clk_i),
        .rst_n     (rstn_i),
        .flush     (redirect_i),
        .push      (buf_push),
        .push_data ({pend_pc, imem_rdata_i}),
        .pop       (buf_pop),
        .head_c    (buf_head),
        .count     (buf_count)
    );

    assign imem_addr_o = pc_q;
    assign id_valid_o  = (buf_count != '0);
    assign id_pc_o     = buf_head[ENTRY_W-1:WORD_WIDTH];
    assign id_instr_o  = buf_head[WORD_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable in-order memory model.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;

    int checks   = 0;
    int failures = 0;

    int unsigned lat = 1;
    int unsigned cyc = 0;
    logic [31:0] mem_addr_q[$];
    int unsigned mem_due_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];
    logic [31:0] grant_q[$];

    fetch_unit dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_valid_o    (id_valid_o),
        .id_instr_o    (id_instr_o),
        .id_pc_o       (id_pc_o),
        .id_ready_i    (id_ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic bit resp_due();
        return (mem_due_q.size() != 0) && (mem_due_q[0] <= cyc);
    endfunction

    // One clock cycle: drive at negedge, sample settled outputs, advance the memory model at posedge.
    task automatic step(input bit redir, input logic [31:0] tgt);
        bit          resp;
        bit          grant;
        bit          acc;
        logic [31:0] gaddr;
        redirect_i    = redir;
        redirect_pc_i = tgt;
        resp          = resp_due();
        imem_rvalid_i = resp;
        imem_rdata_i  = resp ? instr_of(mem_addr_q[0]) : 32'h0;
        #1;
        grant = imem_req_o && imem_gnt_i;
        gaddr = imem_addr_o;
        acc   = id_valid_o && id_ready_i && !redir;
        if (acc) begin
            got_pc.push_back(id_pc_o);
            got_instr.push_back(id_instr_o);
        end
        @(posedge clk_i);
        if (resp) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end
        if (grant) begin
            mem_addr_q.push_back(gaddr);
            mem_due_q.push_back(cyc + lat);
            grant_q.push_back(gaddr);
        end
        cyc++;
        @(negedge clk_i);
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
    endtask

    task automatic reset_dut();
        rstn_i        = 1'b0;
        redirect_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        mem_addr_q.delete();
        mem_due_q.delete();
        got_pc.delete();
        got_instr.delete();
        grant_q.delete();
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    // The buffer must never be pushed while full without a same-cycle pop.
    always @(negedge clk_i) begin
        #3;
        if (rstn_i) begin
            check("buf_overflow",
                  32'(dut.buf_push && (dut.buf_count == 2'd2) && !dut.buf_pop), 32'd0);
        end
    end

    initial begin
        int n0;
        bit found;
        rstn_i        = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        id_ready_i    = 1'b1;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_valid", 32'(id_valid_o), 32'd0);
        check("rst_instr", id_instr_o, 32'h0);
        check("rst_pc", id_pc_o, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);

        // Streaming with single-cycle memory
        rstn_i = 1'b1;
        lat    = 1;
        check("s1_reset_cycle_req", 32'(imem_req_o), 32'd0);
        step(1'b0, 32'h0);
        check("s1_first_req", 32'(imem_req_o), 32'd1);
        check("s1_first_addr", imem_addr_o, 32'h0);
        repeat (14) step(1'b0, 32'h0);
        check("s1_count_ok", 32'(got_pc.size() >= 6), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("s1_pc", got_pc[i], 32'(4 * i));
            check("s1_instr", got_instr[i], instr_of(32'(4 * i)));
        end

        // Decode stall fills the buffer and blocks issue
        reset_dut();
        lat        = 1;
        id_ready_i = 1'b0;
        repeat (9) step(1'b0, 32'h0);
        check("s2_req_blocked", 32'(imem_req_o), 32'd0);
        check("s2_valid", 32'(id_valid_o), 32'd1);
        check("s2_pc_held", id_pc_o, 32'h0);
        check("s2_instr_held", id_instr_o, instr_of(32'h0));
        check("s2_addr_held", imem_addr_o, 32'h8);
        check("s2_nothing_taken", 32'(got_pc.size()), 32'd0);
        id_ready_i = 1'b1;
        repeat (10) step(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("s2_pc", got_pc[i], 32'(4 * i));
            check("s2_instr", got_instr[i], instr_of(32'(4 * i)));
        end
        check("s2_resume_grant", grant_q[2], 32'h8);

        // Redirect with two slow requests in flight
        reset_dut();
        lat = 3;
        step(1'b0, 32'h0);
        step(1'b1, 32'h10);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        check("s3_inflight_block", 32'(imem_req_o), 32'd0);
        step(1'b1, 32'h103);
        check("s3_target_addr", imem_addr_o, 32'h100);
        check("s3_no_req", 32'(imem_req_o), 32'd0);
        check("s3_buf_empty", 32'(id_valid_o), 32'd0);
        repeat (12) step(1'b0, 32'h0);
        check("s3_next_grant", grant_q[2], 32'h100);
        check("s3_first_pc", got_pc[0], 32'h100);
        check("s3_first_instr", got_instr[0], instr_of(32'h100));
        check("s3_second_pc", got_pc[1], 32'h104);

        // Redirect in the same cycle as a response and a ready decode
        reset_dut();
        lat = 2;
        step(1'b0, 32'h0);
        repeat (4) step(1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_due()) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 32'h0);
        end
        check("s4_resp_found", 32'(found), 32'd1);
        n0 = got_pc.size();
        check("s4_pre_count", 32'(n0), 32'd2);
        step(1'b1, 32'h200);
        check("s4_buf_empty", 32'(id_valid_o), 32'd0);
        check("s4_target_addr", imem_addr_o, 32'h200);
        repeat (10) step(1'b0, 32'h0);
        check("s4_first_pc", got_pc[2], 32'h200);
        check("s4_first_instr", got_instr[2], instr_of(32'h200));

        // PC wraps at the top of the address space; target low bits are cleared
        reset_dut();
        lat = 1;
        step(1'b0, 32'h0);
        step(1'b1, 32'hFFFF_FFFE);
        check("s5_aligned", imem_addr_o, 32'hFFFF_FFFC);
        step(1'b0, 32'h0);
        check("s5_wrap_addr", imem_addr_o, 32'h0);
        repeat (8) step(1'b0, 32'h0);
        check("s5_pc0", got_pc[0], 32'hFFFF_FFFC);
        check("s5_pc1", got_pc[1], 32'h0);
        check("s5_pc2", got_pc[2], 32'h4);

        // Asynchronous reset mid-burst
        check("s6_busy", 32'(id_valid_o || imem_req_o || (mem_addr_q.size() != 0)), 32'd1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("s6_req", 32'(imem_req_o), 32'd0);
        check("s6_valid", 32'(id_valid_o), 32'd0);
        check("s6_pc", id_pc_o, 32'h0);
        check("s6_instr", id_instr_o, 32'h0);
        check("s6_addr", imem_addr_o, 32'h0);
        @(negedge clk_i);
        reset_dut();
        check("s6_reset_cycle_req", 32'(imem_req_o), 32'd0);
        step(1'b0, 32'h0);
        check("s6_first_req", 32'(imem_req_o), 32'd1);
        check("s6_first_addr", imem_addr_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
